// File: rtl/key_debounce_arbiter_pkg.sv
// key_pkg: shared FSM encoding and key constants for the debounce arbiter
package key_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_FILTER = 1'b1
    } state_t;

    localparam int   DEBOUNCE_20MS = 1000000;
    localparam logic KEY_RELEASED  = 1'b1;

endpackage

// File: rtl/key_debounce_arbiter_if.sv
// key_debounce_arbiter_if: raw key pins in, debounced state and change events out
interface key_debounce_arbiter_if #(
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = $clog2(NUM_KEYS)
);

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_state;
    logic                key_flag;
    logic [IDX_W-1:0]    key_idx;
    logic                busy;

    modport master (
        output key_in,
        input  key_state, key_flag, key_idx, busy
    );

    modport slave (
        input  key_in,
        output key_state, key_flag, key_idx, busy
    );

endinterface

// File: rtl/key_debounce_arbiter_sync.sv
// key_sync_bank: two-flop synchronizer per key, resets to the released level
module key_sync_bank
    import key_pkg::*;
#(
    parameter int NUM_KEYS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] i_d,
    output logic [NUM_KEYS-1:0] o_q
);

    logic [NUM_KEYS-1:0] r_s1;
    logic [NUM_KEYS-1:0] r_s2;

    // shift raw pins through two flops to tame metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= {NUM_KEYS{KEY_RELEASED}};
            r_s2 <= {NUM_KEYS{KEY_RELEASED}};
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/key_debounce_arbiter.sv
// key_debounce_arbiter: debounces many keys with one round-robin-shared counter
module key_debounce_arbiter
    import key_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int CNT_MAX  = DEBOUNCE_20MS,
    parameter int IDX_W    = $clog2(NUM_KEYS),
    parameter int CNT_W    = $clog2(CNT_MAX)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    key_debounce_arbiter_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    r_sel;
    logic [IDX_W-1:0]    w_sel_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [NUM_KEYS-1:0] r_key_state;
    logic [NUM_KEYS-1:0] w_key_state_nxt;
    logic                r_flag;
    logic                w_flag_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [NUM_KEYS-1:0] w_ksync;
    logic [NUM_KEYS-1:0] w_pend;
    logic [IDX_W-1:0]    w_sel_inc;

    // first pending key at or after ptr, wrapping around the key count
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_KEYS-1:0] p,
        input logic [IDX_W-1:0]    ptr
    );
        logic             found;
        logic [IDX_W-1:0] k;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            k = IDX_W'((int'(ptr) + i) % NUM_KEYS);
            if (!found && p[k]) begin
                rr_pick = k;
                found   = 1'b1;
            end
        end
    endfunction

    key_sync_bank #(.NUM_KEYS(NUM_KEYS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.key_in),
        .o_q   (w_ksync)
    );

    // a key needs service for as long as its synced level disagrees with the debounced one
    assign w_pend    = w_ksync ^ r_key_state;
    assign w_sel_inc = (r_sel == IDX_W'(NUM_KEYS - 1)) ? '0 : r_sel + 1'b1;

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_key_state <= {NUM_KEYS{KEY_RELEASED}};
            r_flag      <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_ptr       <= w_ptr_nxt;
            r_key_state <= w_key_state_nxt;
            r_flag      <= w_flag_nxt;
            r_idx       <= w_idx_nxt;
        end
    end

    // grant, filter, abort on bounce (which beats terminal count), or commit
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_key_state_nxt = r_key_state;
        w_flag_nxt      = 1'b0;
        w_idx_nxt       = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (|w_pend) begin
                    w_sel_nxt   = rr_pick(w_pend, r_ptr);
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (w_ksync[r_sel] == r_key_state[r_sel]) begin
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_sel_inc;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(CNT_MAX - 1)) begin
                    w_key_state_nxt[r_sel] = ~r_key_state[r_sel];
                    w_flag_nxt             = 1'b1;
                    w_idx_nxt              = r_sel;
                    w_ptr_nxt              = w_sel_inc;
                    w_cnt_nxt              = '0;
                    w_state_nxt            = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.key_state = r_key_state;
    assign bus.key_flag  = r_flag;
    assign bus.key_idx   = r_idx;
    assign bus.busy      = (r_state == ST_FILTER);

endmodule
